// File: rtl/bsg_counter_set_en_rr_ctrl.sv
// bsg_counter_set_en_rr_ctrl: round-robin arbiter feeding set/increment commands from num_req_p requesters into one shared width_p-bit counter
// ports: clk_i, reset_n_i (sync active-low), stall_i, v_i/op_i/val_i per-requester commands, yumi_o accept, count_o, grant_v_o, grant_id_o, wrap_o
module bsg_counter_set_en_rr_ctrl #(
  parameter int width_p = 3,
  parameter int num_req_p = 4,
  localparam int lg_req_lp = (num_req_p > 2) ? $clog2(num_req_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           stall_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p-1:0]           op_i,
  input  logic [num_req_p*width_p-1:0]   val_i,
  output logic [num_req_p-1:0]           yumi_o,
  output logic [width_p-1:0]             count_o,
  output logic                           grant_v_o,
  output logic [lg_req_lp-1:0]           grant_id_o,
  output logic                           wrap_o
);
  logic [lg_req_lp-1:0] last_r, gnt;
  logic found;
  int idx;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = 0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx = (int'(last_r) + i) % num_req_p;
      if (!found && v_i[idx] && !stall_i && reset_n_i) begin
        found = 1'b1;
        gnt = lg_req_lp'(idx);
      end
    end
    yumi_o = found ? (num_req_p'(1) << gnt) : '0;
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      count_o <= '0;
      last_r <= lg_req_lp'(num_req_p - 1);
      grant_v_o <= 1'b0;
      grant_id_o <= '0;
      wrap_o <= 1'b0;
    end else begin
      grant_v_o <= found;
      wrap_o <= found && !op_i[gnt] && (&count_o);
      if (found) begin
        count_o <= op_i[gnt] ? val_i[gnt*width_p +: width_p] : count_o + 1'b1;
        last_r <= gnt;
        grant_id_o <= gnt;
      end
    end
endmodule

// File: tb/tb_bsg_counter_set_en_rr_ctrl.sv
// tb_bsg_counter_set_en_rr_ctrl: directed vectors with a grant scoreboard checked by an independent monitor
module tb_bsg_counter_set_en_rr_ctrl;
  logic clk = 0, reset_n_i = 0, stall_i = 0;
  logic [3:0] v_i = '0, op_i = '0, yumi_o;
  logic [11:0] val_i = '0;
  logic [2:0] count_o;
  logic grant_v_o, wrap_o;
  logic [1:0] grant_id_o;
  logic [5:0] q[$];
  int vecs = 0, errs = 0;
  bsg_counter_set_en_rr_ctrl #(.width_p(3), .num_req_p(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .stall_i(stall_i), .v_i(v_i), .op_i(op_i),
    .val_i(val_i), .yumi_o(yumi_o), .count_o(count_o), .grant_v_o(grant_v_o),
    .grant_id_o(grant_id_o), .wrap_o(wrap_o));
  always #5 clk = ~clk;
  function automatic logic [11:0] mkval(int k, logic [2:0] x);
    return 12'(x) << (3*k);
  endfunction
  task automatic chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic vec(logic rn, logic st, logic [3:0] v, logic [3:0] op, logic [11:0] val,
                     logic [3:0] ey, logic [1:0] eid, logic [2:0] ecnt, logic ew);
    @(negedge clk);
    reset_n_i = rn; stall_i = st; v_i = v; op_i = op; val_i = val;
    #1 chk("yumi", yumi_o, ey);
    if (ey != 0) q.push_back({eid, ecnt, ew});
    @(posedge clk);
  endtask
  task automatic st(logic [2:0] cnt, logic gv, logic w);
    #1;
    chk("count", count_o, cnt);
    chk("grant_v", grant_v_o, gv);
    chk("wrap", wrap_o, w);
  endtask
  task automatic idle();
    vec(1, 0, 4'h0, 4'h0, '0, 4'h0, 0, 0, 0);
  endtask
  always @(negedge clk)
    if (grant_v_o) begin
      if (q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_grant: id %0d count %0d wrap %0d", grant_id_o, count_o, wrap_o);
      end else begin
        logic [5:0] e;
        e = q.pop_front();
        chk("grant_id", grant_id_o, e[5:4]);
        chk("grant_count", count_o, e[3:1]);
        chk("grant_wrap", wrap_o, e[0]);
      end
    end
  initial begin
    vec(0, 0, 4'hf, 4'h0, '0, 4'h0, 0, 0, 0);
    vec(0, 0, 4'hf, 4'h0, '0, 4'h0, 0, 0, 0);
    st(0, 0, 0);
    chk("reset_id", grant_id_o, 0);
    idle();
    st(0, 0, 0);
    vec(1, 0, 4'b0100, 4'b0100, mkval(2, 5), 4'b0100, 2, 5, 0);
    vec(1, 0, 4'b0100, 4'b0000, '0, 4'b0100, 2, 6, 0);
    vec(1, 0, 4'b0100, 4'b0000, '0, 4'b0100, 2, 7, 0);
    vec(1, 0, 4'b0100, 4'b0000, '0, 4'b0100, 2, 0, 1);
    st(0, 1, 1);
    idle();
    st(0, 0, 0);
    vec(0, 0, 4'h0, 4'h0, '0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      vec(1, 0, 4'hf, 4'h0, '0, 4'(1 << (i % 4)), 2'(i % 4), 3'(i + 1), i == 7);
    vec(1, 0, 4'hf, 4'h0, '0, 4'b0001, 0, 1, 0);
    vec(1, 0, 4'hf, 4'h0, '0, 4'b0010, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      vec(1, 1, 4'hf, 4'h0, '0, 4'h0, 0, 0, 0);
      st(2, 0, 0);
    end
    vec(1, 0, 4'hf, 4'h0, '0, 4'b0100, 2, 3, 0);
    vec(0, 0, 4'h0, 4'h0, '0, 4'h0, 0, 0, 0);
    vec(1, 0, 4'b1001, 4'b0001, mkval(0, 7), 4'b0001, 0, 7, 0);
    vec(1, 0, 4'b1000, 4'b0000, '0, 4'b1000, 3, 0, 1);
    vec(1, 0, 4'b0010, 4'b0000, '0, 4'b0010, 1, 1, 0);
    idle();
    st(1, 0, 0);
    vec(0, 0, 4'h0, 4'h0, '0, 4'h0, 0, 0, 0);
    vec(1, 0, 4'b0010, 4'b0010, mkval(1, 6), 4'b0010, 1, 6, 0);
    vec(0, 0, 4'b0010, 4'b0000, '0, 4'h0, 0, 0, 0);
    st(0, 0, 0);
    chk("reset_mid_id", grant_id_o, 0);
    vec(1, 0, 4'hf, 4'h0, '0, 4'b0001, 0, 1, 0);
    idle();
    idle();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
